// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: controller states, keyboard command bytes, timing helpers.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      BITS,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] RSP_ACK     = 8'hFA;

   function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
      return (clk_hz / 1_000_000) * us;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Processor-side byte port of the PS/2 transmitter: valid/ready offer plus status pulses.
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_busy, tx_done, tx_error
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_busy, tx_done, tx_error
   );
endinterface

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchronizers for the raw PS/2 clock/data lines plus a falling-edge detector
// on the synchronized clock; fall_o is valid 2 cycles after the raw edge, no backpressure.
module ps2_sync (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_s_o,
   output logic data_s_o,
   output logic fall_o
);

   logic [1:0] clk_meta_q;
   logic [1:0] data_meta_q;
   logic       clk_prev_q;

   // Idle PS/2 lines are pulled high, so everything resets to 1 to avoid a false fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta_q  <= 2'b11;
         data_meta_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_meta_q  <= {clk_meta_q[0], ps2_clk_in};
         data_meta_q <= {data_meta_q[0], ps2_data_in};
         clk_prev_q  <= clk_meta_q[1];
      end
   end

   assign clk_s_o  = clk_meta_q[1];
   assign data_s_o = data_meta_q[1];
   assign fall_o   = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-bit frame, ACK check, timeout.
// Accepts one byte only in IDLE (tx_ready); all outputs registered; tx_valid while busy is ignored.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned INHIBIT_US = 100,
   parameter int unsigned TIMEOUT_US = 15000
) (
   input  logic         clk,
   input  logic         reset,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);

   localparam int unsigned INHIBIT_CYC = us_to_cyc(CLK_HZ, INHIBIT_US);
   localparam int unsigned TIMEOUT_CYC = us_to_cyc(CLK_HZ, TIMEOUT_US);
   localparam int unsigned CNT_MAX     = max_u(INHIBIT_CYC, TIMEOUT_CYC);
   localparam int          CNT_W       = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);

   logic clk_s;
   logic data_s;
   logic fall;

   ps2_state_e       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [9:0]       shift_q,   shift_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic             clk_oe_q,  clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             ready_q,   ready_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic             err_q,     err_d;
   logic             timeout;
   logic             abort;

   ps2_sync u_sync (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .clk_s_o     (clk_s),
      .data_s_o    (data_s),
      .fall_o      (fall)
   );

   // A pending limit is pre-empted by a fall in the same cycle: the edge wins.
   assign timeout = (cnt_q == TIMEOUT_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      abort     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx.tx_valid && ready_q) begin
               shift_d  = {1'b1, ~^tx.tx_data, tx.tx_data};
               clk_oe_d = 1'b1;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_q == INHIBIT_LAST) begin
               data_oe_d = 1'b1;
               state_d   = START;
            end
         end
         START: begin
            clk_oe_d  = 1'b0;
            bit_cnt_d = '0;
            cnt_d     = '0;
            state_d   = BITS;
         end
         BITS: begin
            if (fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b0, shift_q[9:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               cnt_d     = '0;
               if (bit_cnt_q == 4'd9) begin
                  state_d = ACK;
               end
            end else if (timeout) begin
               abort = 1'b1;
            end
         end
         ACK: begin
            if (fall) begin
               cnt_d = '0;
               if (!data_s) begin
                  state_d = WAIT_IDLE;
               end else begin
                  abort = 1'b1;
               end
            end else if (timeout) begin
               abort = 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (clk_s && data_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (fall) begin
               cnt_d = '0;
            end else if (timeout) begin
               abort = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort) begin
         err_d     = 1'b1;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         state_d   = IDLE;
      end

      // Ready lags the return to IDLE by a cycle so it never overlaps a done/error pulse.
      ready_d = (state_d == IDLE) && (state_q == IDLE);
      busy_d  = ~ready_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx.tx_ready = ready_q;
   assign tx.tx_busy  = busy_q;
   assign tx.tx_done  = done_q;
   assign tx.tx_error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 keyboard model (40-cycle clock period).
`timescale 1ns/1ps
module tb_ps2_host_tx;
   import ps2_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       dev_clk;
   logic       dev_data;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       ps2_clk_line;
   logic       ps2_data_line;
   int         n_tests = 0;
   int         n_fail = 0;
   int         n_done;
   int         n_err;
   int         inh_cnt;
   logic       start_bit;
   logic [9:0] cap;

   always #5 clk = ~clk;

   assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
   assign ps2_data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx_if tx_if ();

   ps2_host_tx #(
      .CLK_HZ     (1_000_000),
      .INHIBIT_US (100),
      .TIMEOUT_US (2000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx          (tx_if),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_data_in (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (tx_if.tx_done === 1'b1) n_done++;
      if (tx_if.tx_error === 1'b1) n_err++;
   endtask

   task automatic start_tx(input logic [7:0] b, input logic hold, input logic [7:0] junk);
      int w;
      n_done = 0;
      n_err  = 0;
      w      = 0;
      while (tx_if.tx_ready !== 1'b1 && w < 100) begin
         step();
         w++;
      end
      chk("ready_before_send", tx_if.tx_ready, 1);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = b;
      step();
      chk("accept_clk_oe", ps2_clk_oe, 1);
      chk("accept_busy", tx_if.tx_busy, 1);
      tx_if.tx_valid = hold;
      tx_if.tx_data  = junk;
      inh_cnt = 0;
      while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh_cnt < 400) begin
         inh_cnt++;
         step();
      end
      chk("inhibit_cycles", inh_cnt, 100);
      chk("start_data_oe", ps2_data_oe, 1);
      chk("start_clk_oe", ps2_clk_oe, 1);
      step();
      chk("start_release", ps2_clk_oe, 0);
      start_bit = ps2_data_line;
   endtask

   task automatic dev_clock(input int nfalls);
      repeat (5) step();
      for (int i = 0; i < nfalls; i++) begin
         dev_clk = 1'b0;
         repeat (20) step();
         dev_clk = 1'b1;
         cap[i]  = ps2_data_line;
         repeat (20) step();
      end
   endtask

   task automatic dev_ack(input logic ack);
      if (ack) dev_data = 1'b0;
      repeat (5) step();
      dev_clk = 1'b0;
      repeat (20) step();
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (10) step();
   endtask

   initial begin
      reset          = 1'b1;
      dev_clk        = 1'b1;
      dev_data       = 1'b1;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'h00;
      n_done         = 0;
      n_err          = 0;
      cap            = '0;
      repeat (3) step();
      chk("rst_ready", tx_if.tx_ready, 1);
      chk("rst_busy", tx_if.tx_busy, 0);
      chk("rst_done", tx_if.tx_done, 0);
      chk("rst_error", tx_if.tx_error, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      reset = 1'b0;
      repeat (2) step();

      // 0xED: data 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1
      start_tx(CMD_SET_LED, 1'b0, 8'h00);
      chk("ed_start_bit", start_bit, 0);
      dev_clock(10);
      chk("ed_frame", cap, 10'h3ED);
      dev_ack(1'b1);
      chk("ed_done", n_done, 1);
      chk("ed_error", n_err, 0);
      chk("ed_ready", tx_if.tx_ready, 1);
      chk("ed_clk_rel", ps2_clk_oe, 0);
      chk("ed_data_rel", ps2_data_oe, 0);

      // 0xF4 with tx_valid held and junk data during the transfer
      start_tx(CMD_ENABLE, 1'b1, 8'h55);
      chk("f4_start_bit", start_bit, 0);
      dev_clock(10);
      tx_if.tx_valid = 1'b0;
      chk("f4_frame", cap, 10'h2F4);
      dev_ack(1'b1);
      chk("f4_done", n_done, 1);
      repeat (20) step();
      chk("f4_no_second_accept", ps2_clk_oe, 0);
      chk("f4_ready_after", tx_if.tx_ready, 1);

      start_tx(8'h00, 1'b0, 8'h00);
      dev_clock(10);
      chk("00_frame", cap, 10'h300);
      dev_ack(1'b1);
      chk("00_done", n_done, 1);

      start_tx(CMD_RESET, 1'b0, 8'h00);
      dev_clock(10);
      chk("ff_frame", cap, 10'h3FF);
      dev_ack(1'b1);
      chk("ff_done", n_done, 1);
      chk("ff_error", n_err, 0);

      // device withholds ACK
      start_tx(CMD_ENABLE, 1'b0, 8'h00);
      dev_clock(10);
      dev_ack(1'b0);
      chk("nack_error", n_err, 1);
      chk("nack_done", n_done, 0);
      chk("nack_clk_rel", ps2_clk_oe, 0);
      chk("nack_data_rel", ps2_data_oe, 0);
      chk("nack_ready", tx_if.tx_ready, 1);

      // device never clocks: error exactly 2000 cycles after START exits
      start_tx(8'h00, 1'b0, 8'h00);
      repeat (1999) step();
      chk("to_not_early", tx_if.tx_error, 0);
      chk("to_data_held", ps2_data_oe, 1);
      step();
      chk("to_error_pulse", tx_if.tx_error, 1);
      chk("to_clk_rel", ps2_clk_oe, 0);
      chk("to_data_rel", ps2_data_oe, 0);
      chk("to_not_ready_in_pulse", tx_if.tx_ready, 0);
      step();
      chk("to_error_one_cycle", tx_if.tx_error, 0);
      chk("to_ready_after", tx_if.tx_ready, 1);
      chk("to_error_count", n_err, 1);
      chk("to_done_count", n_done, 0);

      // reset after fall 5 of 0xED (bit4 = 0, so data is being driven)
      start_tx(CMD_SET_LED, 1'b0, 8'h00);
      dev_clock(5);
      chk("mid_bit4_driven", ps2_data_oe, 1);
      reset = 1'b1;
      step();
      chk("mid_rst_clk_oe", ps2_clk_oe, 0);
      chk("mid_rst_data_oe", ps2_data_oe, 0);
      chk("mid_rst_ready", tx_if.tx_ready, 1);
      chk("mid_rst_busy", tx_if.tx_busy, 0);
      chk("mid_rst_no_pulse", n_done + n_err, 0);
      reset = 1'b0;
      repeat (3) step();
      start_tx(CMD_RESET, 1'b0, 8'h00);
      dev_clock(10);
      chk("post_rst_frame", cap, 10'h3FF);
      dev_ack(1'b1);
      chk("post_rst_done", n_done, 1);
      chk("post_rst_error", n_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
